// File: rtl/instr_fetch_decode_pkg.sv
// Shared widths and decode payload types for the PDP-8 style fetch/decode unit.
package instr_fetch_decode_pkg;

    localparam int unsigned ADDR_WIDTH     = 12;
    localparam int unsigned DATA_WIDTH     = 12;
    localparam int unsigned MEM_ADDR_WIDTH = 9;

    typedef struct packed {
        logic                      AND;
        logic                      TAD;
        logic                      ISZ;
        logic                      DCA;
        logic                      JMS;
        logic                      JMP;
        logic                      NOP;
        logic [MEM_ADDR_WIDTH-1:0] mem_inst_addr;
    } pdp_mem_opcode_s;

    typedef struct packed {
        logic NOP;
        logic IAC;
        logic RAL;
        logic RTL;
        logic RAR;
        logic RTR;
        logic CML;
        logic CMA;
        logic CIA;
        logic CLL;
        logic CLA1;
        logic CLA_CLL;
        logic HLT;
        logic OSR;
        logic SKP;
        logic SNL;
        logic SZL;
        logic SZA;
        logic SNA;
        logic SMA;
        logic SPA;
        logic CLA2;
    } pdp_op7_opcode_s;

endpackage

// File: rtl/instr_fetch_decode.sv
// Instruction fetch and decode: one memory read per instruction, decoded into
// one-hot memory-reference / operate flag structs, handshaken by stall.
module instr_fetch_decode
    import instr_fetch_decode_pkg::*;
#(
    parameter logic [ADDR_WIDTH-1:0] START_ADDR = 12'o200
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  stall,
    input  logic [ADDR_WIDTH-1:0] PC_value,
    output logic                  ifu_rd_req,
    output logic [ADDR_WIDTH-1:0] ifu_rd_addr,
    input  logic [DATA_WIDTH-1:0] ifu_rd_data,
    output logic [ADDR_WIDTH-1:0] base_addr,
    output pdp_mem_opcode_s       pdp_mem_opcode,
    output pdp_op7_opcode_s       pdp_op7_opcode
);

    typedef enum logic [2:0] {
        IDLE          = 3'd0,
        SEND_REQ      = 3'd1,
        DATA_RCV      = 3'd2,
        DECODE        = 3'd3,
        WAIT_STALL_HI = 3'd4,
        WAIT_STALL_LO = 3'd5
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] fetch_addr_q, fetch_addr_d;
    logic                  req_q, req_d;
    logic [DATA_WIDTH-1:0] ir_q, ir_d;
    pdp_mem_opcode_s       mem_op_q, mem_op_d;
    pdp_op7_opcode_s       op7_op_q, op7_op_d;

    pdp_mem_opcode_s       mem_dec;
    pdp_op7_opcode_s       op7_dec;

    // Instruction decode; unlisted operate encodings collapse to NOP
    always_comb begin
        mem_dec = '0;
        op7_dec = '0;
        case (ir_q[11:9])
            3'd0: mem_dec.AND = 1'b1;
            3'd1: mem_dec.TAD = 1'b1;
            3'd2: mem_dec.ISZ = 1'b1;
            3'd3: mem_dec.DCA = 1'b1;
            3'd4: mem_dec.JMS = 1'b1;
            3'd5: mem_dec.JMP = 1'b1;
            3'd6: mem_dec.NOP = 1'b1;
            default: begin
                case (ir_q)
                    12'o7001: op7_dec.IAC     = 1'b1;
                    12'o7004: op7_dec.RAL     = 1'b1;
                    12'o7006: op7_dec.RTL     = 1'b1;
                    12'o7010: op7_dec.RAR     = 1'b1;
                    12'o7012: op7_dec.RTR     = 1'b1;
                    12'o7020: op7_dec.CML     = 1'b1;
                    12'o7040: op7_dec.CMA     = 1'b1;
                    12'o7041: op7_dec.CIA     = 1'b1;
                    12'o7100: op7_dec.CLL     = 1'b1;
                    12'o7200: op7_dec.CLA1    = 1'b1;
                    12'o7300: op7_dec.CLA_CLL = 1'b1;
                    12'o7402: op7_dec.HLT     = 1'b1;
                    12'o7404: op7_dec.OSR     = 1'b1;
                    12'o7410: op7_dec.SKP     = 1'b1;
                    12'o7420: op7_dec.SNL     = 1'b1;
                    12'o7430: op7_dec.SZL     = 1'b1;
                    12'o7440: op7_dec.SZA     = 1'b1;
                    12'o7450: op7_dec.SNA     = 1'b1;
                    12'o7500: op7_dec.SMA     = 1'b1;
                    12'o7510: op7_dec.SPA     = 1'b1;
                    12'o7600: op7_dec.CLA2    = 1'b1;
                    default:  op7_dec.NOP     = 1'b1;
                endcase
            end
        endcase
        if (ir_q[11:9] < 3'd6) begin
            mem_dec.mem_inst_addr = ir_q[8:0];
        end
    end

    // Fetch sequencing; the request flop is set on entry to SEND_REQ
    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        req_d        = 1'b0;
        ir_d         = ir_q;
        mem_op_d     = mem_op_q;
        op7_op_d     = op7_op_q;
        case (state_q)
            IDLE: begin
                fetch_addr_d = START_ADDR;
                req_d        = 1'b1;
                state_d      = SEND_REQ;
            end
            SEND_REQ: begin
                state_d = DATA_RCV;
            end
            DATA_RCV: begin
                ir_d    = ifu_rd_data;
                state_d = DECODE;
            end
            DECODE: begin
                mem_op_d = mem_dec;
                op7_op_d = op7_dec;
                state_d  = WAIT_STALL_HI;
            end
            WAIT_STALL_HI: begin
                if (stall) begin
                    state_d = WAIT_STALL_LO;
                end
            end
            WAIT_STALL_LO: begin
                if (!stall) begin
                    fetch_addr_d = PC_value;
                    req_d        = 1'b1;
                    state_d      = SEND_REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            fetch_addr_q <= '0;
            req_q        <= 1'b0;
            ir_q         <= '0;
            mem_op_q     <= '0;
            op7_op_q     <= '0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            req_q        <= req_d;
            ir_q         <= ir_d;
            mem_op_q     <= mem_op_d;
            op7_op_q     <= op7_op_d;
        end
    end

    assign ifu_rd_req     = req_q;
    assign ifu_rd_addr    = fetch_addr_q;
    assign base_addr      = START_ADDR;
    assign pdp_mem_opcode = mem_op_q;
    assign pdp_op7_opcode = op7_op_q;

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Directed and randomized bench for instr_fetch_decode against a table-driven decode model.
module tb_instr_fetch_decode;
    import instr_fetch_decode_pkg::*;

    localparam logic [11:0] OP7_TAB [22] = '{
        12'o7000, 12'o7001, 12'o7004, 12'o7006, 12'o7010, 12'o7012,
        12'o7020, 12'o7040, 12'o7041, 12'o7100, 12'o7200, 12'o7300,
        12'o7402, 12'o7404, 12'o7410, 12'o7420, 12'o7430, 12'o7440,
        12'o7450, 12'o7500, 12'o7510, 12'o7600
    };
    localparam logic [11:0] EXTRA_TAB [3] = '{12'o7003, 12'o7401, 12'o6001};

    logic            clk = 1'b0;
    logic            reset_n;
    logic            stall;
    logic [11:0]     PC_value;
    logic            ifu_rd_req;
    logic [11:0]     ifu_rd_addr;
    logic [11:0]     ifu_rd_data = '0;
    logic [11:0]     base_addr;
    pdp_mem_opcode_s pdp_mem_opcode;
    pdp_op7_opcode_s pdp_op7_opcode;

    logic [11:0] mem [4096];
    int          checks = 0;
    int          errors = 0;
    int          req_count = 0;
    logic [11:0] prev_instr;

    wire [15:0] mem_vec = pdp_mem_opcode;
    wire [21:0] op7_vec = pdp_op7_opcode;

    instr_fetch_decode #(.START_ADDR(12'o200)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .stall          (stall),
        .PC_value       (PC_value),
        .ifu_rd_req     (ifu_rd_req),
        .ifu_rd_addr    (ifu_rd_addr),
        .ifu_rd_data    (ifu_rd_data),
        .base_addr      (base_addr),
        .pdp_mem_opcode (pdp_mem_opcode),
        .pdp_op7_opcode (pdp_op7_opcode)
    );

    always #5 clk = ~clk;

    // Memory with one-cycle read latency
    always @(posedge clk) begin
        if (ifu_rd_req) ifu_rd_data <= mem[ifu_rd_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected memory-reference struct: opcode = instr / 512, address = instr % 512
    function automatic logic [15:0] exp_mem(input logic [11:0] ir);
        int op;
        op = int'(ir) / 512;
        if (op < 6) return 16'((1 << (15 - op)) | (int'(ir) % 512));
        if (op == 6) return 16'(1 << 9);
        return 16'd0;
    endfunction

    // Expected operate struct: table position selects the flag, anything else is NOP
    function automatic logic [21:0] exp_op7(input logic [11:0] ir);
        if (int'(ir) / 512 != 7) return 22'd0;
        for (int k = 0; k < 22; k++) begin
            if (ir == OP7_TAB[k]) return 22'(1) << (21 - k);
        end
        return 22'(1) << 21;
    endfunction

    // Per-cycle protocol watch: request pulse width, one-hot flags, output stability
    logic        mon_req_prev = 1'b0;
    logic        mon_rst_prev = 1'b0;
    logic [37:0] mon_out_prev = '0;
    int          mon_since = 100;
    always @(negedge clk) begin
        int cur_since;
        cur_since = ifu_rd_req ? 0 : ((mon_since < 100) ? mon_since + 1 : 100);
        if (reset_n && mon_rst_prev) begin
            check("req_pulse", 32'(ifu_rd_req && mon_req_prev), 32'd0);
            check("onehot", 32'($countones({mem_vec[15:9], op7_vec}) <= 1), 32'd1);
            if ({mem_vec, op7_vec} != mon_out_prev)
                check("stable_outside_decode", 32'(cur_since), 32'd3);
            if (ifu_rd_req) req_count++;
        end
        mon_since    = reset_n ? cur_since : 100;
        mon_req_prev = reset_n ? ifu_rd_req : 1'b0;
        mon_rst_prev = reset_n;
        mon_out_prev = {mem_vec, op7_vec};
    end

    task automatic tick();
        @(negedge clk);
    endtask

    // Entered at a negedge in WAIT_STALL_HI with stall low; leaves the same way
    task automatic fetch_one(input logic [11:0] pc, input logic [11:0] instr,
                             input int hi_cyc, input int lo_cyc, input bit pulse);
        int snap;
        mem[pc]  = instr;
        PC_value = pc;
        snap     = req_count;
        repeat (hi_cyc) tick();
        check("hold_mem", 32'(mem_vec), 32'(exp_mem(prev_instr)));
        check("hold_op7", 32'(op7_vec), 32'(exp_op7(prev_instr)));
        stall = 1'b1;
        repeat (lo_cyc) tick();
        stall = 1'b0;
        check("no_req_while_waiting", 32'(req_count - snap), 32'd0);
        tick();
        check("req", 32'(ifu_rd_req), 32'd1);
        check("req_addr", 32'(ifu_rd_addr), 32'(pc));
        tick();
        if (pulse) stall = 1'b1;
        tick();
        tick();
        stall = 1'b0;
        check("dec_mem", 32'(mem_vec), 32'(exp_mem(instr)));
        check("dec_op7", 32'(op7_vec), 32'(exp_op7(instr)));
        check("base_addr", 32'(base_addr), 32'o200);
        prev_instr = instr;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 12'($urandom_range(0, 4095));
        mem[12'o200] = 12'o1234;
        reset_n  = 1'b0;
        stall    = 1'b0;
        PC_value = '0;
        #1;
        check("rst_req", 32'(ifu_rd_req), 32'd0);
        check("rst_addr", 32'(ifu_rd_addr), 32'd0);
        check("rst_mem", 32'(mem_vec), 32'd0);
        check("rst_op7", 32'(op7_vec), 32'd0);
        check("rst_base", 32'(base_addr), 32'o200);
        repeat (3) tick();
        reset_n = 1'b1;
        check("idle_req", 32'(ifu_rd_req), 32'd0);
        tick();
        check("first_req", 32'(ifu_rd_req), 32'd1);
        check("first_addr", 32'(ifu_rd_addr), 32'o200);
        tick();
        check("first_req_drop", 32'(ifu_rd_req), 32'd0);
        tick();
        tick();
        check("first_mem", 32'(mem_vec), 32'(exp_mem(12'o1234)));
        check("first_tad", 32'(pdp_mem_opcode.TAD), 32'd1);
        check("first_op7", 32'(op7_vec), 32'd0);
        prev_instr = 12'o1234;

        fetch_one(12'o201, 12'($urandom_range(0, 4095)), 2, 5, 1'b0);
        fetch_one(12'($urandom_range(0, 4095)), 12'o7402, 10, 3, 1'b0);

        for (int k = 0; k < 22; k++)
            fetch_one(12'($urandom_range(0, 4095)), OP7_TAB[k],
                      $urandom_range(0, 3), $urandom_range(1, 5), 1'($urandom_range(0, 1)));
        for (int k = 0; k < 3; k++)
            fetch_one(12'($urandom_range(0, 4095)), EXTRA_TAB[k],
                      $urandom_range(0, 3), $urandom_range(1, 5), 1'($urandom_range(0, 1)));

        fetch_one(12'o7777, 12'($urandom_range(0, 4095)), 1, 2, 1'b0);
        for (int n = 0; n < 40; n++) begin
            logic [11:0] ins;
            ins = ($urandom_range(0, 1) == 1) ? OP7_TAB[$urandom_range(0, 21)]
                                              : 12'($urandom_range(0, 4095));
            fetch_one(12'($urandom_range(0, 4095)), ins,
                      $urandom_range(0, 3), $urandom_range(1, 6), 1'($urandom_range(0, 1)));
        end

        // Reset while the fetch of 0300 is on the bus
        mem[12'o300] = 12'o5123;
        PC_value = 12'o300;
        stall = 1'b1;
        tick();
        stall = 1'b0;
        tick();
        check("mid_req", 32'(ifu_rd_req), 32'd1);
        check("mid_addr", 32'(ifu_rd_addr), 32'o300);
        reset_n = 1'b0;
        #1;
        check("mid_rst_req", 32'(ifu_rd_req), 32'd0);
        check("mid_rst_addr", 32'(ifu_rd_addr), 32'd0);
        check("mid_rst_mem", 32'(mem_vec), 32'd0);
        check("mid_rst_op7", 32'(op7_vec), 32'd0);
        check("mid_rst_base", 32'(base_addr), 32'o200);
        tick();
        tick();
        reset_n = 1'b1;
        check("restart_idle", 32'(ifu_rd_req), 32'd0);
        tick();
        check("restart_req", 32'(ifu_rd_req), 32'd1);
        check("restart_addr", 32'(ifu_rd_addr), 32'o200);
        tick();
        tick();
        tick();
        check("restart_mem", 32'(mem_vec), 32'(exp_mem(12'o1234)));
        check("restart_op7", 32'(op7_vec), 32'd0);
        prev_instr = 12'o1234;
        fetch_one(12'o4321, 12'o7041, 2, 2, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/instr_fetch_decode.md
INSTR_FETCH_DECODE -- requirements
Module: instr_fetch_decode

Interface
REQ-001 SHALL have parameter: START_ADDR, 12'o200, fetch address of first instruction and value driven on base_addr.
REQ-002 SHALL have ports:
  - clk  in  1  single clock; all state on rising edge.
  - reset_n  in  1  reset, asynchronous, active-low.
  - stall  in  1  execution unit busy.
  - PC_value  in  ADDR_WIDTH  next-instruction address from execution unit.
  - ifu_rd_req  out  1  memory read request.
  - ifu_rd_addr  out  ADDR_WIDTH  memory read address.
  - ifu_rd_data  in  DATA_WIDTH  memory read data.
  - base_addr  out  ADDR_WIDTH  program start address.
  - pdp_mem_opcode  out  pdp_mem_opcode_s  memory-reference decode: AND, TAD, ISZ, DCA, JMS, JMP, NOP, mem_inst_addr[8:0].
  - pdp_op7_opcode  out  pdp_op7_opcode_s  operate decode: NOP, IAC, RAL, RTL, RAR, RTR, CML, CMA, CIA, CLL, CLA1, CLA_CLL, HLT, OSR, SKP, SNL, SZL, SZA, SNA, SMA, SPA, CLA2.

Function
REQ-003 SHALL implement FSM IDLE -> SEND_REQ -> DATA_RCV -> DECODE -> WAIT_STALL_HI -> WAIT_STALL_LO -> SEND_REQ.
REQ-004 IDLE SHALL last exactly one cycle after reset release, loading fetch address register with START_ADDR.
REQ-005 SEND_REQ: ifu_rd_req=1 for exactly one cycle, ifu_rd_addr=fetch address; ifu_rd_req=0 in every other state.
REQ-006 DATA_RCV: IR SHALL capture ifu_rd_data at end of cycle (memory read latency fixed at one cycle).
REQ-007 DECODE: both decode structs SHALL be registered from IR at end of cycle, visible from the following cycle, held stable until the next DECODE.
REQ-008 IR[11:9] 0..5 SHALL set AND/TAD/ISZ/DCA/JMS/JMP respectively, mem_inst_addr=IR[8:0], op7 struct all zero.
REQ-009 IR[11:9]=6 (IOT) SHALL set mem NOP=1, mem_inst_addr=0, op7 struct all zero.
REQ-010 IR[11:9]=7 SHALL set mem struct all zero and exactly one op7 field.
REQ-011 Group 1 (IR[8]=0), octal: 7000 NOP, 7001 IAC, 7004 RAL, 7006 RTL, 7010 RAR, 7012 RTR, 7020 CML, 7040 CMA, 7041 CIA, 7100 CLL, 7200 CLA1, 7300 CLA_CLL.
REQ-012 Group 2 (IR[8]=1, IR[0]=0), octal: 7402 HLT, 7404 OSR, 7410 SKP, 7420 SNL, 7430 SZL, 7440 SZA, 7450 SNA, 7500 SMA, 7510 SPA, 7600 CLA2.
REQ-013 Any other opcode-7 encoding (combined microinstructions, IR[8]=1 with IR[0]=1) SHALL decode to op7 NOP=1 only.
REQ-014 Decode structs SHALL be one-hot across all flag fields (mem_inst_addr excluded); never two flags set.
REQ-015 WAIT_STALL_HI SHALL remain until stall=1, then enter WAIT_STALL_LO; stall already 1 on entry advances next cycle.
REQ-016 WAIT_STALL_LO SHALL remain while stall=1; on first cycle with stall=0, fetch address <= PC_value, next state SEND_REQ.
REQ-017 stall SHALL be ignored in IDLE, SEND_REQ, DATA_RCV, DECODE.
REQ-018 HLT SHALL receive no special fetch handling; halting is by execution unit holding stall=1.
REQ-019 base_addr SHALL equal START_ADDR at all times after reset release.
REQ-020 Addresses SHALL be ADDR_WIDTH (12) bits, no arithmetic or increment in this block; PC_value 12'o7777 passed unchanged.

Reset
REQ-021 reset_n=0 SHALL immediately (asynchronously) force: state IDLE, ifu_rd_req=0, ifu_rd_addr=0, IR=0, both decode structs all zero, base_addr=START_ADDR.
REQ-022 Reset asserted mid-fetch (SEND_REQ/DATA_RCV) SHALL drop ifu_rd_req at once, discard the read; restart fetches from START_ADDR.

Verification
REQ-023 Reset release, mem[0200]=1234 -> 1 cycle IDLE, ifu_rd_req pulse with addr 0200, TAD=1, mem_inst_addr=9'o234, op7 all zero 3 cycles after request.
REQ-024 stall 0->1 (5 cycles)->0 with PC_value=0201 -> exactly one ifu_rd_req, addr 0201, in cycle after stall falls.
REQ-025 Sweep IR over 7000,7001,7004,7006,7010,7012,7020,7040,7041,7100,7200,7300,7402,7404,7410,7420,7430,7440,7450,7500,7510,7600 -> matching single op7 flag; 7003, 7401 -> op7 NOP; 6001 -> mem NOP.
REQ-026 stall held 0 after DECODE -> no new request; FSM stays WAIT_STALL_HI, outputs unchanged.
REQ-027 reset_n pulsed low during SEND_REQ for fetch of 0300 -> ifu_rd_req low same cycle, structs zero; after release next request addr 0200.
REQ-028 Assertions every cycle: ifu_rd_req never high two consecutive cycles; decode one-hot; outputs stable outside DECODE update.
